// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
// reg_dump : walks select_y over a code range, waits for y to settle, and
//            streams each captured word out over a valid/ready handshake.
// Revision  : 1.0
// ============================================================================
module reg_dump #(
  parameter int unsigned FIRST_SEL = 0,
  parameter int unsigned LAST_SEL  = 15,
  parameter int unsigned SETTLE    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dump_req,
  input  logic        abort,
  input  logic [15:0] y,
  output logic [3:0]  select_y,
  output logic [15:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] c_FIRST_SEL   = 4'(FIRST_SEL);
  localparam logic [3:0] c_LAST_SEL    = 4'(LAST_SEL);
  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SEND   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= 4'd0;
      cnt_q   <= 4'd0;
      data_q  <= 16'd0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          sel_d   = c_FIRST_SEL;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == c_SETTLE_LAST) begin
          data_d  = y;
          idx_d   = sel_q;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SEND: begin
        // abort wins over a coincident handshake: the word is not delivered
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (sel_q == c_LAST_SEL) begin
            state_d = S_DONE;
          end else begin
            sel_d   = sel_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign select_y  = sel_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ============================================================================
// tb_reg_dump : directed scoreboard bench for reg_dump (default range and a
//               narrowed 3..5 range instance sharing clock and reset).
// Revision    : 1.0
// ============================================================================
module tb_reg_dump;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        dump_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic [15:0] y_a, data_a;
  logic [3:0]  sel_a, idx_a;
  logic        valid_a, busy_a, done_a;

  logic        dump_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [15:0] y_b, data_b;
  logic [3:0]  sel_b, idx_b;
  logic        valid_b, busy_b, done_b;

  // Processor model: debug word is a fixed tag plus the select code
  assign y_a = 16'hA000 + {12'h000, sel_a};
  assign y_b = 16'hA000 + {12'h000, sel_b};

  reg_dump u_dut_a (
    .clock(clk), .reset(rst_n), .dump_req(dump_a), .abort(abort_a), .y(y_a),
    .select_y(sel_a), .out_data(data_a), .out_idx(idx_a), .out_valid(valid_a),
    .out_ready(ready_a), .busy(busy_a), .done(done_a)
  );

  reg_dump #(.FIRST_SEL(3), .LAST_SEL(5), .SETTLE(2)) u_dut_b (
    .clock(clk), .reset(rst_n), .dump_req(dump_b), .abort(abort_b), .y(y_b),
    .select_y(sel_b), .out_data(data_b), .out_idx(idx_b), .out_valid(valid_b),
    .out_ready(ready_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_w;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_a, data_a, idx_a, valid_a, busy_a, done_a} !== 27'h0) begin
      errors++; $display("FAIL reset_a: got %h want 0", {sel_a, data_a, idx_a, valid_a, busy_a, done_a});
    end
    checks++;
    if ({sel_b, data_b, idx_b, valid_b, busy_b, done_b} !== 27'h0) begin
      errors++; $display("FAIL reset_b: got %h want 0", {sel_b, data_b, idx_b, valid_b, busy_b, done_b});
    end
    dump_a = 1'b1;
    repeat (3) tick();
    checks++;
    if ({valid_a, busy_a, done_a} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: got %b want 000", {valid_a, busy_a, done_a});
    end
    dump_a = 1'b0;
    rst_n  = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy got %b want 0", busy_a);
    end
  endtask

  task automatic test_full_dump();
    int edges, first, got, dones;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 16'hA000 + 16'(i)});
    ready_a = 1'b1;
    dump_a  = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    dump_a = 1'b0;
    first = 0; got = 0; dones = 0;
    for (int c = 0; c < 70; c++) begin
      if (valid_a) begin
        if (first == 0) first = edges;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_word: got extra idx %0d want none", idx_a);
        end else begin
          exp_w = exp_q.pop_front();
          if ({idx_a, data_a} !== exp_w) begin
            errors++; $display("FAIL full_word: got %h want %h", {idx_a, data_a}, exp_w);
          end
        end
        got++;
      end
      if (done_a) dones++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (first !== 3) begin errors++; $display("FAIL full_latency: got %0d want 3", first); end
    checks++;
    if (got !== 16) begin errors++; $display("FAIL full_count: got %0d want 16", got); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", dones); end
    checks++;
    if ({busy_a, sel_a} !== 5'h0F) begin
      errors++; $display("FAIL full_end: busy/sel got %h want 0f", {busy_a, sel_a});
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL full_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int stall, got, dones;
    logic [19:0] hold_w;
    exp_q.delete();
    for (int i = 3; i <= 5; i++) exp_q.push_back({4'(i), 16'hA000 + 16'(i)});
    hold_w  = '0;
    ready_b = 1'b0;
    dump_b  = 1'b1;
    tick();
    dump_b = 1'b0;
    stall = 0; got = 0; dones = 0;
    for (int c = 0; c < 80; c++) begin
      ready_b = 1'b0;
      if (valid_b) begin
        checks++;
        if (stall == 0) begin
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL stall_word: got extra idx %0d want none", idx_b);
          end else begin
            exp_w = exp_q.pop_front();
            if ({idx_b, data_b} !== exp_w) begin
              errors++; $display("FAIL stall_word: got %h want %h", {idx_b, data_b}, exp_w);
            end
            hold_w = exp_w;
          end
          got++;
        end else if ({sel_b, idx_b, data_b} !== {hold_w[19:16], hold_w}) begin
          errors++; $display("FAIL stall_hold: got %h want %h", {sel_b, idx_b, data_b}, {hold_w[19:16], hold_w});
        end
        stall++;
        if (stall == 5) ready_b = 1'b1;
      end else begin
        stall = 0;
      end
      if (done_b) dones++;
      tick();
    end
    ready_b = 1'b0;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL stall_count: got %0d want 3", got); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL stall_done: got %0d want 1", dones); end
    checks++;
    if (sel_b !== 4'd5) begin errors++; $display("FAIL stall_sel_end: got %0d want 5", sel_b); end
  endtask

  task automatic test_abort();
    int hs, bad, found;
    logic aborted;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), 16'hA000 + 16'(i)});
    ready_a = 1'b1;
    dump_a  = 1'b1;
    tick();
    dump_a = 1'b0;
    hs = 0; bad = 0; aborted = 1'b0;
    for (int c = 0; c < 40 && !aborted; c++) begin
      if (valid_a) begin
        checks++;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hFFFFF;
        if ({idx_a, data_a} !== exp_w) begin
          errors++; $display("FAIL abort_word: got %h want %h", {idx_a, data_a}, exp_w);
        end
        if (hs == 2) begin
          abort_a = 1'b1;
          aborted = 1'b1;
        end
        hs++;
      end
      if (done_a) bad++;
      tick();
    end
    abort_a = 1'b0;
    checks++;
    if (aborted !== 1'b1) begin errors++; $display("FAIL abort_reach: got %b want 1", aborted); end
    checks++;
    if ({valid_a, busy_a, done_a} !== 3'b000) begin
      errors++; $display("FAIL abort_after: got %b want 000", {valid_a, busy_a, done_a});
    end
    ready_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (valid_a || busy_a || done_a) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d want 0", bad); end
    ready_a = 1'b0;
    dump_a  = 1'b1;
    tick();
    dump_a = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (valid_a) found = 1;
      else tick();
    end
    checks++;
    if ({found[0], idx_a, data_a} !== {1'b1, 4'd0, 16'hA000}) begin
      errors++; $display("FAIL abort_restart: got %h want 10a000", {found[0], idx_a, data_a});
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if ({valid_a, busy_a} !== 2'b00) begin
      errors++; $display("FAIL abort_send: got %b want 00", {valid_a, busy_a});
    end
  endtask

  task automatic test_async_reset();
    int found, bad;
    ready_a = 1'b0;
    dump_a  = 1'b1;
    tick();
    dump_a = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      if (valid_a) found = 1;
      else tick();
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL areset_send: got %0d want 1", found); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel_a, data_a, idx_a, valid_a, busy_a, done_a} !== 27'h0) begin
      errors++; $display("FAIL areset_now: got %h want 0", {sel_a, data_a, idx_a, valid_a, busy_a, done_a});
    end
    #1 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_a || busy_a || done_a) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL areset_quiet: got %0d want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int got, dones, gap;
    exp_q.delete();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 16'hA000 + 16'(i)});
    ready_a = 1'b1;
    dump_a  = 1'b1;
    got = 0; dones = 0; gap = 0;
    for (int c = 0; c < 150; c++) begin
      if (valid_a) begin
        checks++;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hFFFFF;
        if ({idx_a, data_a} !== exp_w) begin
          errors++; $display("FAIL b2b_word: got %h want %h", {idx_a, data_a}, exp_w);
        end
        got++;
      end
      // abort during the idle gap must not stop the held request restarting
      if (gap == 1) begin
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin
          errors++; $display("FAIL b2b_idle: got %b want 00", {busy_a, done_a});
        end
        abort_a = 1'b1;
        gap = 2;
      end else if (gap == 2) begin
        abort_a = 1'b0;
        checks++;
        if ({busy_a, sel_a} !== 5'h10) begin
          errors++; $display("FAIL b2b_restart: got %h want 10", {busy_a, sel_a});
        end
        gap = 0;
      end
      if (done_a) begin
        dones++;
        if (dones == 1) gap = 1;
        else dump_a = 1'b0;
      end
      tick();
    end
    dump_a  = 1'b0;
    abort_a = 1'b0;
    checks++;
    if (dones !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", dones); end
    checks++;
    if (got !== 32) begin errors++; $display("FAIL b2b_count: got %0d want 32", got); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_end: busy got %b want 0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
